// File: rtl/gpr_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_pkg
// Purpose  : Shared sizes, requester encodings and round-robin pointer type
//            for the GPR write-back scheduler.
// Config   : GPR_WB_FWD_EN (optional write-stage forwarding, see top)
// Revision : 1.0  initial release
// ============================================================================
package gpr_wb_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);

   // Requester identities; also the encoding of the round-robin pointer
   typedef enum logic {
      REQ_EX = 1'b0,
      REQ_LD = 1'b1
   } rr_ptr_t;

   // The requester that gets priority after the given one wins a contended cycle
   function automatic rr_ptr_t rr_other(input rr_ptr_t p);
      return (p == REQ_EX) ? REQ_LD : REQ_EX;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gpr_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_if
// Purpose  : Bundles the ALU/load write requests, the decode issue port and
//            the register-file write port of the write-back scheduler.
// Config   : GPR_WB_FWD_EN adds fwd_rs1_hit / fwd_rs2_hit
// Revision : 1.0  initial release
// ============================================================================
interface gpr_wb_if;
   import gpr_wb_pkg::*;

   logic            ex_valid;
   logic [AW-1:0]   ex_rd;
   logic [XLEN-1:0] ex_data;
   logic            ex_ready;

   logic            ld_valid;
   logic [AW-1:0]   ld_rd;
   logic [XLEN-1:0] ld_data;
   logic            ld_ready;

   logic            iss_valid;
   logic [AW-1:0]   iss_rs1;
   logic [AW-1:0]   iss_rs2;
   logic [AW-1:0]   iss_rd;
   logic            iss_wr;
   logic            iss_stall;

   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
`ifdef GPR_WB_FWD_EN
   logic            fwd_rs1_hit;
   logic            fwd_rs2_hit;
`endif

   // Pipeline side: drives requests and issues, observes grants and writes
   modport master (
      output ex_valid, ex_rd, ex_data, input ex_ready,
      output ld_valid, ld_rd, ld_data, input ld_ready,
      output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr, input iss_stall,
      input  wr_en, wr_addr, wr_data
`ifdef GPR_WB_FWD_EN
      , input fwd_rs1_hit, fwd_rs2_hit
`endif
   );

   // Scheduler side
   modport slave (
      input ex_valid, ex_rd, ex_data, output ex_ready,
      input ld_valid, ld_rd, ld_data, output ld_ready,
      input iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr, output iss_stall,
      output wr_en, wr_addr, wr_data
`ifdef GPR_WB_FWD_EN
      , output fwd_rs1_hit, fwd_rs2_hit
`endif
   );

endinterface
`default_nettype wire

// File: rtl/gpr_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : gpr_scoreboard
// Purpose  : Per-register busy bits for writes still in flight, plus the
//            RAW/WAW hazard check that stalls issue.
// Config   : forwarding hits arrive as inputs (tied low when not built)
// Revision : 1.0  initial release
// ============================================================================
module gpr_scoreboard
   import gpr_wb_pkg::*;
(
   input  logic          clk2,
   input  logic          rst,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_rs1,
   input  logic [AW-1:0] iss_rs2,
   input  logic [AW-1:0] iss_rd,
   input  logic          iss_wr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic          fwd_rs1_hit,
   input  logic          fwd_rs2_hit,
   output logic          iss_stall
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic [NREG-1:0] set_vec;
   logic [NREG-1:0] clr_vec;
   logic            set_en;

   // Hazard compare on registered busy only; a forwarded source is not a hazard
   always_comb begin
      iss_stall = iss_valid & ((busy[iss_rs1] & ~fwd_rs1_hit) |
                               (busy[iss_rs2] & ~fwd_rs2_hit) |
                               (iss_wr & busy[iss_rd]));
      set_en    = iss_valid & ~iss_stall & iss_wr & (iss_rd != '0);
   end

   // Next busy vector: a new issue wins over a same-cycle write of a non-busy rd; x0 never busy
   always_comb begin
      set_vec  = set_en ? (NREG'(1) << iss_rd) : '0;
      clr_vec  = clr_en ? (NREG'(1) << clr_addr) : '0;
      busy_nxt = ((busy & ~clr_vec) | set_vec) & ~NREG'(1);
   end

   // Busy register
   always_ff @(posedge clk2) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/gpr_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_sched
// Purpose  : Round-robin share of the GPR write port between the ALU (ex)
//            and load (ld) paths, registered write stage, issue scoreboard.
// Config   : `define GPR_WB_FWD_EN to expose write-stage forwarding hits and
//            let a hit source bypass the busy stall.
// Revision : 1.0  initial release
// ============================================================================
module gpr_wb_sched
   import gpr_wb_pkg::*;
(
   input  logic     clk2,
   input  logic     rst,
   gpr_wb_if.slave  bus
);

   rr_ptr_t         rr_ptr;
   rr_ptr_t         rr_ptr_nxt;
   logic            gnt_ex;
   logic            gnt_ld;
   logic            gnt_any;
   logic [AW-1:0]   gnt_rd;
   logic [XLEN-1:0] gnt_data;
   logic            wr_en_q;
   logic [AW-1:0]   wr_addr_q;
   logic [XLEN-1:0] wr_data_q;
   logic            fwd_hit1;
   logic            fwd_hit2;

   // Round-robin pointer register
   always_ff @(posedge clk2) begin
      if (rst) begin
         rr_ptr <= REQ_EX;
      end else begin
         rr_ptr <= rr_ptr_nxt;
      end
   end

   // Pointer only moves when both requesters contend
   always_comb begin
      rr_ptr_nxt = (bus.ex_valid & bus.ld_valid) ? rr_other(rr_ptr) : rr_ptr;
   end

   // Grant decode and winning payload select
   always_comb begin
      gnt_ex   = bus.ex_valid & (~bus.ld_valid | (rr_ptr == REQ_EX));
      gnt_ld   = bus.ld_valid & (~bus.ex_valid | (rr_ptr == REQ_LD));
      gnt_any  = gnt_ex | gnt_ld;
      gnt_rd   = gnt_ex ? bus.ex_rd   : bus.ld_rd;
      gnt_data = gnt_ex ? bus.ex_data : bus.ld_data;
   end

   assign bus.ex_ready = gnt_ex;
   assign bus.ld_ready = gnt_ld;

   // Write stage: x0 grants are consumed without enabling the GPR write
   always_ff @(posedge clk2) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else if (gnt_any) begin
         wr_en_q   <= (gnt_rd != '0);
         wr_addr_q <= gnt_rd;
         wr_data_q <= gnt_data;
      end else begin
         wr_en_q   <= 1'b0;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

`ifdef GPR_WB_FWD_EN
   assign fwd_hit1 = wr_en_q & (wr_addr_q == bus.iss_rs1) & (bus.iss_rs1 != '0);
   assign fwd_hit2 = wr_en_q & (wr_addr_q == bus.iss_rs2) & (bus.iss_rs2 != '0);
   assign bus.fwd_rs1_hit = fwd_hit1;
   assign bus.fwd_rs2_hit = fwd_hit2;
`else
   assign fwd_hit1 = 1'b0;
   assign fwd_hit2 = 1'b0;
`endif

   gpr_scoreboard u_scoreboard (
      .clk2        (clk2),
      .rst         (rst),
      .iss_valid   (bus.iss_valid),
      .iss_rs1     (bus.iss_rs1),
      .iss_rs2     (bus.iss_rs2),
      .iss_rd      (bus.iss_rd),
      .iss_wr      (bus.iss_wr),
      .clr_en      (gnt_any & (gnt_rd != '0)),
      .clr_addr    (gnt_rd),
      .fwd_rs1_hit (fwd_hit1),
      .fwd_rs2_hit (fwd_hit2),
      .iss_stall   (bus.iss_stall)
   );

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_wb_sched
// Purpose  : Self-checking bench for gpr_wb_sched: directed scenarios plus
//            randomized traffic against a behavioural reference model.
// Config   : follows GPR_WB_FWD_EN when defined
// Revision : 1.0  initial release
// ============================================================================
module tb_gpr_wb_sched;
   import gpr_wb_pkg::*;

   logic clk2 = 1'b0;
   logic rst  = 1'b1;
   always #5 clk2 = ~clk2;

   gpr_wb_if bus ();

   gpr_wb_sched dut (
      .clk2 (clk2),
      .rst  (rst),
      .bus  (bus)
   );

   typedef struct {
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
   } wr_t;

   typedef struct {
      bit              r;
      bit              exv;
      logic [AW-1:0]   exrd;
      logic [XLEN-1:0] exd;
      bit              ldv;
      logic [AW-1:0]   ldrd;
      logic [XLEN-1:0] ldd;
      bit              iv;
      logic [AW-1:0]   rs1;
      logic [AW-1:0]   rs2;
      logic [AW-1:0]   rd;
      bit              iw;
   } stim_t;

   // Reference model state
   wr_t           expq[$];
   bit            pend[NREG];
   bit            ld_turn;      // 1: load wins the next contended cycle
   bit            ws_en;        // model of the write stage contents
   logic [AW-1:0] ws_addr;
   bit            prev_rst;
   bit            ex_acc;
   bit            ld_acc;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.r = 0; s.exv = 0; s.exrd = '0; s.exd = '0;
      s.ldv = 0; s.ldrd = '0; s.ldd = '0;
      s.iv = 0; s.rs1 = '0; s.rs2 = '0; s.rd = '0; s.iw = 0;
      return s;
   endfunction

   // One clock: drive, check combinational responses, advance the model
   task automatic step(input stim_t s);
      bit            e_ex, e_ld, e_st, h1, h2;
      logic [AW-1:0] g_rd;
      wr_t           w;
      @(posedge clk2);
      #1;
      if (prev_rst) begin
         chk("rst_wr_en",   {31'd0, bus.wr_en}, 32'd0);
         chk("rst_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
         chk("rst_wr_data", bus.wr_data, 32'd0);
      end
      rst           = s.r;
      bus.ex_valid  = s.exv;  bus.ex_rd = s.exrd;  bus.ex_data = s.exd;
      bus.ld_valid  = s.ldv;  bus.ld_rd = s.ldrd;  bus.ld_data = s.ldd;
      bus.iss_valid = s.iv;   bus.iss_rs1 = s.rs1; bus.iss_rs2 = s.rs2;
      bus.iss_rd    = s.rd;   bus.iss_wr = s.iw;
      #1;
      if (s.r) begin
         for (int i = 0; i < NREG; i++) pend[i] = 0;
         ld_turn = 0; ws_en = 0; ws_addr = '0;
         ex_acc = 0; ld_acc = 0;
      end else begin
         e_ex = s.exv && (!s.ldv || !ld_turn);
         e_ld = s.ldv && (!s.exv || ld_turn);
         chk("ex_ready", {31'd0, bus.ex_ready}, {31'd0, e_ex});
         chk("ld_ready", {31'd0, bus.ld_ready}, {31'd0, e_ld});
`ifdef GPR_WB_FWD_EN
         h1 = ws_en && (ws_addr == s.rs1) && (s.rs1 != 0);
         h2 = ws_en && (ws_addr == s.rs2) && (s.rs2 != 0);
         chk("fwd_rs1_hit", {31'd0, bus.fwd_rs1_hit}, {31'd0, h1});
         chk("fwd_rs2_hit", {31'd0, bus.fwd_rs2_hit}, {31'd0, h2});
`else
         h1 = 0;
         h2 = 0;
`endif
         e_st = s.iv && ((pend[s.rs1] && !h1) || (pend[s.rs2] && !h2) || (s.iw && pend[s.rd]));
         chk("iss_stall", {31'd0, bus.iss_stall}, {31'd0, e_st});
         if (s.exv && s.ldv) ld_turn = !ld_turn;
         if (e_ex || e_ld) begin
            g_rd = e_ex ? s.exrd : s.ldrd;
            if (g_rd != 0) begin
               w.a = g_rd;
               w.d = e_ex ? s.exd : s.ldd;
               expq.push_back(w);
               pend[g_rd] = 0;
            end
            ws_en   = (g_rd != 0);
            ws_addr = g_rd;
         end else begin
            ws_en = 0;
         end
         if (s.iv && !e_st && s.iw && s.rd != 0) pend[s.rd] = 1;
         ex_acc = e_ex;
         ld_acc = e_ld;
      end
      prev_rst = s.r;
   endtask

   // Monitor: every enabled write seen by the GPR must be the next expected one
   initial begin
      wr_t e;
      forever begin
         @(negedge clk2);
         if (bus.wr_en === 1'b1) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write actual=x%0d:%h required=none at %0t",
                        bus.wr_addr, bus.wr_data, $time);
            end else begin
               e = expq.pop_front();
               chk("wr_addr", {27'd0, bus.wr_addr}, {27'd0, e.a});
               chk("wr_data", bus.wr_data, e.d);
            end
         end
      end
   end

   // Randomized traffic; requesters hold their request until it is granted
   task automatic run_random(input int n, input int pex, input int pld, input int piss, input int prst);
      stim_t s;
      s = idle();
      for (int c = 0; c < n; c++) begin
         if (!s.exv || ex_acc) begin
            s.exv  = ($urandom_range(0, 99) < pex);
            s.exrd = AW'($urandom_range(0, 7));
            s.exd  = $urandom;
         end
         if (!s.ldv || ld_acc) begin
            s.ldv  = ($urandom_range(0, 99) < pld);
            s.ldrd = AW'($urandom_range(0, 7));
            s.ldd  = $urandom;
         end
         s.iv  = ($urandom_range(0, 99) < piss);
         s.rs1 = AW'($urandom_range(0, 7));
         s.rs2 = AW'($urandom_range(0, 7));
         s.rd  = AW'($urandom_range(0, 7));
         s.iw  = $urandom_range(0, 1) == 1;
         s.r   = ($urandom_range(0, 999) < prst);
         if (s.r) s.iv = 0;
         step(s);
         if (s.r) begin
            ex_acc = 0;
            ld_acc = 0;
         end
      end
   endtask

   initial begin
      stim_t s;
      prev_rst = 0;
      ex_acc = 0;
      ld_acc = 0;

      // Reset with both requesters already valid
      s = idle();
      s.r = 1; s.exv = 1; s.exrd = 5'd1; s.exd = 32'h11; s.ldv = 1; s.ldrd = 5'd2; s.ldd = 32'h22;
      step(s);
      step(s);

      // Contended requests: EX, LD, EX, LD
      run_random(4, 100, 100, 0, 0);
      for (int i = 0; i < 2; i++) step(idle());

      // RAW hazard on x5 until its write is granted
      s = idle(); s.iv = 1; s.rd = 5'd5; s.iw = 1;
      step(s);
      s = idle(); s.iv = 1; s.rs1 = 5'd5;
      for (int i = 0; i < 3; i++) step(s);
      s.exv = 1; s.exrd = 5'd5; s.exd = 32'hCAFE_0005;
      step(s);
      s.exv = 0;
      step(s);

      // Load to x0 is consumed without a register write
      s = idle(); s.ldv = 1; s.ldrd = 5'd0; s.ldd = 32'h0000_DEAD;
      step(s);
      step(idle());

      // Write of x3 in the write stage while x3 is busy again and read as rs2
      s = idle(); s.exv = 1; s.exrd = 5'd3; s.exd = 32'h55; s.iv = 1; s.rd = 5'd3; s.iw = 1;
      step(s);
      s = idle(); s.iv = 1; s.rs2 = 5'd3;
      step(s);
      s = idle(); s.exv = 1; s.exrd = 5'd3; s.exd = 32'h66;
      step(s);
      step(idle());

      // Reset while x7 is busy and a request is held
      s = idle(); s.iv = 1; s.rd = 5'd7; s.iw = 1;
      step(s);
      s = idle(); s.r = 1; s.exv = 1; s.exrd = 5'd7; s.exd = 32'h77;
      step(s);
      step(idle());
      s = idle(); s.iv = 1; s.rs1 = 5'd7; s.rd = 5'd7; s.iw = 1;
      step(s);
      s = idle(); s.exv = 1; s.exrd = 5'd7; s.exd = 32'h707;
      step(s);

      // Random traffic, including occasional resets
      run_random(600, 60, 60, 60, 5);
      for (int i = 0; i < 3; i++) step(idle());

      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
